// File: rtl/fp_pkg.sv
// Shared types, constants and helpers for the single-precision FP datapath.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          LATENCY  = 4;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'd255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

    function automatic logic [4:0] lzc28(input logic [27:0] v);
        logic found;
        lzc28 = 5'd28;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && v[i]) begin
                lzc28 = 5'(27 - i);
                found = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fp_addsub_if.sv
// Operand/result bundle of the FP add unit with its done/serv handshake.
interface fp_addsub_if;
    import fp_pkg::*;

    logic [31:0] op1;
    logic [31:0] op2;
    logic        add_start;
    logic        add_serv;
    logic [31:0] add_result;
    logic        add_done;
    logic        add_busy;

    modport master (
        output op1, op2, add_start, add_serv,
        input  add_result, add_done, add_busy
    );

    modport slave (
        input  op1, op2, add_start, add_serv,
        output add_result, add_done, add_busy
    );

endinterface

// File: rtl/fp_lzc28.sv
// 28-bit leading-zero counter for post-add normalisation.
module fp_lzc28
    import fp_pkg::*;
(
    input  logic [27:0] value,
    output logic [4:0]  count
);

    assign count = lzc28(value);

endmodule

// File: rtl/fp_addsub.sv
// Four-stage pipelined IEEE-754 single adder (flush-to-zero, RNE).
module fp_addsub
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    fp_addsub_if.slave   bus
);

    fp32_t       a_in, b_in;
    logic [30:0] mag1, mag2;
    logic        swap;
    logic        nan1, nan2, inf1, inf2;
    logic        spec_hit;
    logic [31:0] spec_val;

    assign a_in = bus.op1;
    assign b_in = bus.op2;
    assign mag1 = (a_in.exp == 8'd0) ? 31'd0 : bus.op1[30:0];
    assign mag2 = (b_in.exp == 8'd0) ? 31'd0 : bus.op2[30:0];
    assign swap = mag2 > mag1;

    assign nan1 = (a_in.exp == EXP_MAX) && (a_in.frac != 23'd0);
    assign nan2 = (b_in.exp == EXP_MAX) && (b_in.frac != 23'd0);
    assign inf1 = (a_in.exp == EXP_MAX) && (a_in.frac == 23'd0);
    assign inf2 = (b_in.exp == EXP_MAX) && (b_in.frac == 23'd0);

    always_comb begin
        spec_hit = 1'b1;
        spec_val = QNAN;
        if (nan1 || nan2 || (inf1 && inf2 && (a_in.sign != b_in.sign)))
            spec_val = QNAN;
        else if (inf1)
            spec_val = {a_in.sign, EXP_MAX, 23'd0};
        else if (inf2)
            spec_val = {b_in.sign, EXP_MAX, 23'd0};
        else if (mag1 == 31'd0 && mag2 == 31'd0)
            spec_val = {a_in.sign & b_in.sign, 31'd0};
        else
            spec_hit = 1'b0;
    end

    logic        s1_sign, s1_sub, s1_spec;
    logic [31:0] s1_spec_val;
    logic [7:0]  s1_exp_a, s1_exp_b;
    logic [23:0] s1_man_a, s1_man_b;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_spec     <= 1'b0;
            s1_spec_val <= '0;
            s1_exp_a    <= '0;
            s1_exp_b    <= '0;
            s1_man_a    <= '0;
            s1_man_b    <= '0;
        end else begin
            s1_sign     <= swap ? b_in.sign : a_in.sign;
            s1_sub      <= a_in.sign ^ b_in.sign;
            s1_spec     <= spec_hit;
            s1_spec_val <= spec_val;
            s1_exp_a    <= swap ? mag2[30:23] : mag1[30:23];
            s1_exp_b    <= swap ? mag1[30:23] : mag2[30:23];
            s1_man_a    <= swap ? {mag2[30:23] != 8'd0, mag2[22:0]}
                                : {mag1[30:23] != 8'd0, mag1[22:0]};
            s1_man_b    <= swap ? {mag1[30:23] != 8'd0, mag1[22:0]}
                                : {mag2[30:23] != 8'd0, mag2[22:0]};
        end
    end

    // Align B into {man, G, R, S}; anything past R collapses into sticky.
    logic [7:0]  shamt;
    logic [49:0] wide;
    logic [26:0] b_aligned;

    assign shamt = s1_exp_a - s1_exp_b;
    assign wide  = {s1_man_b, 26'd0} >> shamt;

    always_comb begin
        if (shamt >= 8'd27)
            b_aligned = {26'd0, |s1_man_b};
        else
            b_aligned = {wide[49:24], |wide[23:0]};
    end

    logic        s2_sign, s2_sub, s2_spec;
    logic [31:0] s2_spec_val;
    logic [7:0]  s2_exp;
    logic [26:0] s2_man_a, s2_man_b;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            s2_sign     <= 1'b0;
            s2_sub      <= 1'b0;
            s2_spec     <= 1'b0;
            s2_spec_val <= '0;
            s2_exp      <= '0;
            s2_man_a    <= '0;
            s2_man_b    <= '0;
        end else begin
            s2_sign     <= s1_sign;
            s2_sub      <= s1_sub;
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;
            s2_exp      <= s1_exp_a;
            s2_man_a    <= {s1_man_a, 3'd0};
            s2_man_b    <= b_aligned;
        end
    end

    logic        s3_sign, s3_spec;
    logic [31:0] s3_spec_val;
    logic [7:0]  s3_exp;
    logic [27:0] s3_sum;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            s3_sign     <= 1'b0;
            s3_spec     <= 1'b0;
            s3_spec_val <= '0;
            s3_exp      <= '0;
            s3_sum      <= '0;
        end else begin
            s3_sign     <= s2_sign;
            s3_spec     <= s2_spec;
            s3_spec_val <= s2_spec_val;
            s3_exp      <= s2_exp;
            s3_sum      <= s2_sub ? {1'b0, s2_man_a} - {1'b0, s2_man_b}
                                  : {1'b0, s2_man_a} + {1'b0, s2_man_b};
        end
    end

    logic [4:0]         lz, lzm1;
    logic [26:0]        norm;
    logic signed [9:0]  e_norm, e_rnd;
    logic               round_up;
    logic [24:0]        rounded;
    logic [22:0]        frac_out;
    logic [31:0]        packed_res;

    fp_lzc28 u_lzc (
        .value (s3_sum),
        .count (lz)
    );

    assign lzm1 = lz - 5'd1;

    always_comb begin
        if (s3_sum[27]) begin
            norm   = {s3_sum[27:2], |s3_sum[1:0]};
            e_norm = signed'({2'b00, s3_exp} + 10'd1);
        end else begin
            norm   = s3_sum[26:0] << lzm1;
            e_norm = signed'({2'b00, s3_exp} - {5'd0, lzm1});
        end
    end

    // Round to nearest even on {lsb, G, R, S} = norm[3:0].
    assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
    assign e_rnd    = rounded[24] ? e_norm + 10'sd1 : e_norm;
    assign frac_out = rounded[24] ? rounded[23:1] : rounded[22:0];

    always_comb begin
        if (s3_spec)
            packed_res = s3_spec_val;
        else if (s3_sum == 28'd0)
            packed_res = FP_ZERO;
        else if (e_norm <= 10'sd0)
            packed_res = {s3_sign, 31'd0};
        else if (e_rnd >= 10'sd255)
            packed_res = {s3_sign, EXP_MAX, 23'd0};
        else
            packed_res = {s3_sign, e_rnd[7:0], frac_out};
    end

    logic [31:0]        result;
    logic               done;
    logic [LATENCY-1:0] vld;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            result <= '0;
            done   <= 1'b0;
            vld    <= '0;
        end else begin
            result <= packed_res;
            vld    <= {vld[LATENCY-2:0], bus.add_start === 1'b1};
            if (vld[LATENCY-2])
                done <= 1'b1;
            else if (bus.add_serv)
                done <= 1'b0;
        end
    end

    assign bus.add_result = result;
    assign bus.add_done   = done;
    assign bus.add_busy   = |vld;

endmodule

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub: streamed vectors plus handshake/reset checks.
module tb_fp_addsub;

    logic clk = 1'b0;
    logic n_rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    fp_addsub_if bus ();

    fp_addsub dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] q_exp[$];
    string       q_tag[$];

    localparam int NV = 22;
    logic [31:0] vec [NV][3] = '{
        '{32'hC475C000, 32'h4A1FE982, 32'h4A1FDA26},
        '{32'h4475C000, 32'hCA1FE982, 32'hCA1FDA26},
        '{32'h40200000, 32'h40600000, 32'h40C00000},
        '{32'h40300000, 32'h40300000, 32'h40B00000},
        '{32'hC61C4238, 32'hC61C4238, 32'hC69C4238},
        '{32'hC61C4238, 32'h461C4238, 32'h00000000},
        '{32'hC0840000, 32'h40800000, 32'hBE000000},
        '{32'h4475C000, 32'h4A1FE982, 32'h4A1FF8DE},
        '{32'h4A1FE982, 32'h4475C000, 32'h4A1FF8DE},
        '{32'h41480000, 32'h418C0000, 32'h41F00000},
        '{32'h3F800000, 32'h3F800000, 32'h40000000},
        '{32'h3F800000, 32'h33800000, 32'h3F800000},
        '{32'h3F800000, 32'h34400000, 32'h3F800002},
        '{32'h7F800000, 32'h3F800000, 32'h7F800000},
        '{32'h7F800000, 32'hFF800000, 32'h7FC00000},
        '{32'h7F800001, 32'h3F800000, 32'h7FC00000},
        '{32'h80000000, 32'h80000000, 32'h80000000},
        '{32'h00000000, 32'h80000000, 32'h00000000},
        '{32'h00000001, 32'h00000000, 32'h00000000},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
        '{32'h80800001, 32'h00800000, 32'h80000000},
        '{32'h3F800000, 32'hBF800000, 32'h00000000}
    };

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // One operand pair per cycle; result for the pair sampled three edges
    // earlier is compared once four entries are queued.
    task automatic step(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        bus.op1 = a;
        bus.op2 = b;
        @(posedge clk);
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        @(negedge clk);
        if (q_exp.size() == 4)
            check(q_tag.pop_front(), bus.add_result, q_exp.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst         = 1'b1;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.add_start = 1'b0;
        bus.add_serv  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_result", bus.add_result, 32'h0);
        check("rst_done", {31'd0, bus.add_done}, 32'd0);
        check("rst_busy", {31'd0, bus.add_busy}, 32'd0);
        n_rst = 1'b0;

        for (int i = 0; i < NV; i++)
            step($sformatf("vec%0d", i), vec[i][0], vec[i][1], vec[i][2]);
        for (int i = 0; i < 3; i++)
            step("drain", 32'h0, 32'h0, 32'h0);
        q_exp.delete();
        q_tag.delete();
        check("idle_busy", {31'd0, bus.add_busy}, 32'd0);

        bus.op1       = 32'h3F800000;
        bus.op2       = 32'h40000000;
        bus.add_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.add_start = 1'b0;
            check($sformatf("hs_busy_c%0d", c), {31'd0, bus.add_busy}, 32'd1);
            check($sformatf("hs_done_c%0d", c), {31'd0, bus.add_done},
                  (c == 4) ? 32'd1 : 32'd0);
        end
        check("hs_result", bus.add_result, 32'h40400000);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("hs_done_hold", {31'd0, bus.add_done}, 32'd1);
        end
        check("hs_busy_end", {31'd0, bus.add_busy}, 32'd0);
        bus.add_serv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.add_serv = 1'b0;
        check("hs_done_clr", {31'd0, bus.add_done}, 32'd0);

        bus.add_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.add_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, bus.add_busy}, 32'd1);
        n_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", {31'd0, bus.add_busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.add_done}, 32'd0);
        check("mid_rst_result", bus.add_result, 32'h0);
        n_rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_rst_done", {31'd0, bus.add_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_addsub.md
Name: fp_addsub

Overview:
- IEEE-754 single-precision floating-point adder. It computes add_result = op1 + op2.
- Subtraction is performed by the caller flipping the sign bit of op2.
- Used as the add/sub functional unit of the FP datapath.
- Fixed-latency, fully pipelined. A new operand pair is accepted every cycle, with a done/serv handshake for result consumption.

Parameters:
- LATENCY, 4, cycles from operand sample to registered add_result. Fixed; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-high: reset occurs on a clk rising edge while n_rst=1. The name is historical.
- op1  in  32  IEEE-754 single operand A.
- op2  in  32  IEEE-754 single operand B.
- add_start  in  1  marks the operand pair sampled this cycle as a tracked request. X/Z is treated as 0.
- add_serv  in  1  consumer acknowledge; clears add_done.
- add_result  out  32  IEEE-754 single sum.
- add_done  out  1  tracked result available; held until add_serv.
- add_busy  out  1  high while any tracked request is in flight in the pipeline.

Behaviour:
- Reset: every pipeline register, add_result, add_done and add_busy go to 0. Reset has priority over all other inputs, including mid-operation; in-flight work is discarded.
- Sampling and latency:
  - op1/op2 are sampled every cycle regardless of add_start.
  - add_result always reflects the operands sampled LATENCY cycles earlier.
  - With constant operands, add_result is stable from cycle 4 onward.
- Stage 1, unpack/swap:
  - Split each operand into sign, exponent and 24-bit significand. The hidden 1 is used when exp≠0.
  - exp=0 inputs (zero/denormal) are flushed to signed zero.
  - Order the operands by magnitude {exp,frac} so A ≥ B. The result sign is A's sign.
- Stage 2, align: right-shift B's significand by expA−expB.
  - Keep guard and round bits, plus a sticky OR of all bits shifted past them.
  - Shift amounts ≥ 27 leave only sticky.
- Stage 3, add:
  - Add if the signs are equal, else subtract B from A.
  - Width is 28 bits: carry + 24 + G/R/S.
- Stage 4, normalise/round/pack:
  - Carry out: shift right 1 and increment the exponent.
  - Otherwise shift left by the leading-zero count and decrement the exponent.
  - Round to nearest, ties to even. A rounding carry renormalises.
- Zero result: an exact-zero magnitude (e.g. x + (−x)) yields +0 (0x00000000). Both inputs zero yields +0, except (−0)+(−0), which yields −0.
- Underflow: exponent ≤ 0 after normalisation flushes to signed zero.
- Overflow: exponent ≥ 255 yields signed infinity.
- Special inputs (exp=255): if either is NaN, output quiet NaN 0x7FC00000.
  - inf + finite yields that inf.
  - inf + (−inf) yields 0x7FC00000.
- Handshake:
  - add_start travels a LATENCY-deep valid shift register alongside the data.
  - When the valid bit exits stage 4, add_done is set on that edge.
  - add_done clears on the edge where add_serv=1 and no new valid is exiting; set wins when both occur.
  - add_busy = OR of the valid bits in stages 1..4.
- Overlapping requests are allowed. add_done does not count them; consumers needing per-request results must read add_result in the cycle add_done rises.

Decomposition:
- Package fp_pkg:
  - typedef fp32_t as a packed struct {sign, exp[7:0], frac[22:0]}.
  - Constants EXP_BIAS=127, EXP_MAX=255, QNAN=0x7FC00000, FP_ZERO.
  - function for leading-zero count.
- One natural sub-module: fp_lzc28, a 28-bit leading-zero counter used in stage 4.
- Remaining logic is inline pipeline stages.

Test Plan:
- Reset: n_rst=1 for 5 cycles -> add_result=0x00000000, add_done=0, add_busy=0.
- Different exponents, opposite signs: op1=0xC475C000 (−983), op2=0x4A1FE982. Hold 5 cycles -> 0x4A1FDA26. Swapped signs (0x4475C000, 0xCA1FE982) -> 0xCA1FDA26.
- Same exponent: 0x40200000+0x40600000 -> 0x40C00000; 0x40300000+0x40300000 -> 0x40B00000; 0xC61C4238+0xC61C4238 -> 0xC69C4238.
- Cancellation: 0xC61C4238+0x461C4238 -> 0x00000000; 0xC0840000+0x40800000 (−4.125+4) -> 0xBE000000.
- Commutativity/alignment: 0x4475C000+0x4A1FE982 and the swapped pair -> 0x4A1FF8DE both. 0x41480000+0x418C0000 -> 0x41F00000.
- Handshake: pulse add_start with an operand pair.
  - add_busy is high for 4 cycles; add_done rises at cycle 4 with the correct add_result and stays high until add_serv=1, then clears next edge.
  - Reset asserted mid-flight clears add_busy and add_done immediately.
